// File: rtl/ft_recovery_ctrl_if.sv
// Control bundle between the SoC, the lockstep checker and the
// two cores' fetch/reset/boot inputs.
interface ft_recovery_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start_i;
  logic             error_i;
  logic             ckpt_valid_i;
  logic [31:0]      ckpt_pc_i;
  logic             fetch_enable_o;
  logic             core_rst_no;
  logic [31:0]      boot_addr_o;
  logic             recovering_o;
  logic             fatal_o;
  logic [CNT_W-1:0] error_count_o;

  modport master (
    output start_i,
    output error_i,
    output ckpt_valid_i,
    output ckpt_pc_i,
    input  fetch_enable_o,
    input  core_rst_no,
    input  boot_addr_o,
    input  recovering_o,
    input  fatal_o,
    input  error_count_o
  );

  modport slave (
    input  start_i,
    input  error_i,
    input  ckpt_valid_i,
    input  ckpt_pc_i,
    output fetch_enable_o,
    output core_rst_no,
    output boot_addr_o,
    output recovering_o,
    output fatal_o,
    output error_count_o
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Rollback/restart sequencer: drains, resets and restarts both
// lockstep cores from the last checkpoint PC on a mismatch.
module ft_recovery_ctrl #(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0080,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          RESET_CYCLES = 2,
  parameter int          MAX_RETRIES  = 3,
  parameter int          CNT_W        = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ft_recovery_ctrl_if.slave bus
);

  localparam int MAXC = (DRAIN_CYCLES > RESET_CYCLES)
                      ? DRAIN_CYCLES : RESET_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int RW   = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] RESET_LD = TW'(RESET_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    HALT,
    RESET,
    RESTART,
    FATAL
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [31:0]      ckpt_q, ckpt_d;
  logic [31:0]      boot_q, boot_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      retry_q <= '0;
      ckpt_q  <= BOOT_ADDR;
      boot_q  <= BOOT_ADDR;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      ckpt_q  <= ckpt_d;
      boot_q  <= boot_d;
      errc_q  <= errc_d;
    end
  end

  // Next state; inputs only matter in RUN (and start in IDLE)
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    ckpt_d  = ckpt_q;
    boot_d  = boot_q;
    errc_d  = errc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
      end
      RUN: begin
        if (bus.error_i) begin
          if (errc_q != {CNT_W{1'b1}})
            errc_d = errc_q + 1'b1;
          if (retry_q == RETRY_MX) begin
            state_d = FATAL;
          end else begin
            retry_d = retry_q + 1'b1;
            tmr_d   = DRAIN_LD;
            state_d = HALT;
          end
        end else begin
          if (bus.ckpt_valid_i) begin
            ckpt_d  = bus.ckpt_pc_i;
            retry_d = '0;
          end
          if (!bus.start_i) state_d = IDLE;
        end
      end
      HALT: begin
        if (tmr_q == '0) begin
          tmr_d   = RESET_LD;
          boot_d  = ckpt_q;
          state_d = RESET;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RESET: begin
        if (tmr_q == '0) state_d = RESTART;
        else             tmr_d   = tmr_q - 1'b1;
      end
      RESTART: state_d = RUN;
      FATAL:   state_d = FATAL;
      default: state_d = IDLE;
    endcase
  end

  assign bus.fetch_enable_o = (state_q == RUN);
  assign bus.core_rst_no    = !((state_q == RESET) ||
                                (state_q == FATAL));
  assign bus.recovering_o   = (state_q == HALT)  ||
                              (state_q == RESET) ||
                              (state_q == RESTART);
  assign bus.fatal_o        = (state_q == FATAL);
  assign bus.boot_addr_o    = boot_q;
  assign bus.error_count_o  = errc_q;

endmodule

// File: doc/ft_recovery_ctrl.md
# ft_recovery_ctrl

Rollback/restart sequencer for the dual-core fault-tolerant SoC. It sits between the SoC-level fetch enable, the lockstep checker's mismatch flag and the two cores' fetch-enable, reset and boot-address inputs. When a mismatch is flagged, it drains both cores, holds them in reset, then restarts them from the last committed checkpoint PC. After too many consecutive failed retries it parks the system in a fatal state.

## Interface
- BOOT_ADDR, 32'h0000_0080: restart address used before any checkpoint is captured
- DRAIN_CYCLES, 4: cycles spent in HALT with fetch disabled (≥1)
- RESET_CYCLES, 2: cycles the core reset is held low (≥1)
- MAX_RETRIES, 3: consecutive recoveries allowed without an intervening checkpoint (≥1)
- CNT_W, 8: width of the total error counter

- clk_i, in, 1: clock
- rst_ni, in, 1: reset, asynchronous and active-low
- start_i, in, 1: SoC fetch enable, level-sensitive
- error_i, in, 1: lockstep mismatch flag from the fault-tolerance module, sampled each posedge
- ckpt_valid_i, in, 1: one-cycle pulse; both cores agree on a checkpointed commit
- ckpt_pc_i, in, 32: PC for the checkpoint
- fetch_enable_o, out, 1: fetch enable to both cores
- core_rst_no, out, 1: active-low reset to both cores
- boot_addr_o, out, 32: boot address to both cores
- recovering_o, out, 1: high in HALT, RESET and RESTART
- fatal_o, out, 1: high in FATAL
- error_count_o, out, CNT_W: saturating count of accepted errors

## Operation
- States: IDLE, RUN, HALT, RESET, RESTART, FATAL. All outputs are decoded from registered state or registered values (Moore). No combinational input-to-output paths.
- Outputs per state:
  - IDLE: fetch 0, core_rst_no 1
  - RUN: fetch 1, rst 1
  - HALT: fetch 0, rst 1
  - RESET: fetch 0, rst 0
  - RESTART: fetch 0, rst 1
  - FATAL: fetch 0, rst 0
- IDLE→RUN when start_i=1.
- RUN→IDLE when start_i=0 and error_i=0.
- RUN with error_i=1: error takes priority over start_i and ckpt_valid_i.
  - error_count increments, saturating at 2^CNT_W−1.
  - If retry_cnt == MAX_RETRIES, go to FATAL.
  - Otherwise retry_cnt++ and go to HALT.
- RUN with ckpt_valid_i=1 and error_i=0: ckpt_reg ← ckpt_pc_i and retry_cnt ← 0. This applies on the same edge even if start_i=0.
- HALT→RESET after DRAIN_CYCLES cycles in HALT. boot_addr_o ← ckpt_reg on entry to RESET.
- RESET→RESTART after RESET_CYCLES cycles.
- RESTART→RUN after exactly 1 cycle.
- The following are ignored (not counted, not latched) outside RUN: error_i, ckpt_valid_i, start_i. The one exception is start_i in IDLE.
- FATAL is left only by rst_ni.
- A single down-counter is shared by HALT and RESET. It is loaded on state entry.
- ckpt_reg is 32 bits and resets to BOOT_ADDR, so a rollback before any checkpoint restarts from BOOT_ADDR.

## Timing
- Reset values: state IDLE, fetch_enable_o 0, core_rst_no 1, boot_addr_o BOOT_ADDR, recovering_o 0, fatal_o 0, error_count_o 0, retry_cnt 0, ckpt_reg BOOT_ADDR.
- Asserting rst_ni low mid-recovery returns everything to the reset values immediately (asynchronously).
- Start latency: start_i sampled high at edge N → fetch_enable_o high after edge N.
- Error timeline, with error_i sampled high at edge N in RUN:
  - Edge N: fetch_enable_o falls and recovering_o rises.
  - Edge N+DRAIN_CYCLES: core_rst_no falls and boot_addr_o is updated.
  - Edge N+DRAIN_CYCLES+RESET_CYCLES: core_rst_no rises.
  - Edge N+DRAIN_CYCLES+RESET_CYCLES+1: fetch_enable_o rises and recovering_o falls.
  - Total recovery window with the defaults: 7 cycles.
- boot_addr_o is stable for the whole low phase of core_rst_no and for the RESTART cycle.
- error_i held high across multiple RUN cycles: only the first cycle is accepted, because the FSM has already left RUN.
- error_i asserted on the first RUN cycle after RESTART: accepted normally.

## Test plan
- **Normal run:** release reset, hold start_i=1, pulse ckpt with PC 0x0000_00A4 and no errors.
  - fetch_enable_o=1 throughout; error_count_o=0; core_rst_no never falls.
- **Single error after checkpoint:** ckpt 0x0000_00A4, then error_i pulse at edge N.
  - fetch_enable_o=0 at N.
  - core_rst_no=0 during edges N+4..N+5.
  - boot_addr_o=0x0000_00A4.
  - fetch_enable_o=1 at N+7.
  - error_count_o=1.
- **Error before any checkpoint:** → boot_addr_o=0x0000_0080 at restart.
- **Retry exhaustion:** four errors, each on the first RUN cycle after a restart, with no ckpt between them.
  - Three recoveries, then the fourth error → FATAL.
  - fatal_o=1, fetch_enable_o=0, core_rst_no=0, error_count_o=4.
  - Further error_i and start_i toggling has no effect.
- **Simultaneous ckpt_valid_i and error_i in RUN:** ckpt 0x0000_00C0 is discarded.
  - Restart at the previous checkpoint.
  - retry_cnt is not cleared (verified by three further errors reaching FATAL).
- **Async reset during RESET state and counter saturation:**
  - Drop rst_ni mid-recovery → all outputs return to their reset values without waiting for a clock edge.
  - With CNT_W=2, five errors separated by checkpoints → error_count_o sticks at 3.
